// File: rtl/regfile_multiport_if.sv
// Bus bundle for regfile_multiport: normal write/read ports plus the bulk load and dump streams.
// The master side drives requests; the register file sits on the slave side.
interface regfile_multiport_if #(
    parameter int XLEN = 64,
    parameter int AW   = 5,
    parameter int NRD  = 2
);
    logic                  reg_write;
    logic [AW-1:0]         wr_addr;
    logic [XLEN-1:0]       wr_data;
    logic [NRD*AW-1:0]     rd_addr;
    logic [NRD*XLEN-1:0]   rd_data;
    logic                  ld_start;
    logic                  ld_valid;
    logic [XLEN-1:0]       ld_data;
    logic                  ld_ready;
    logic                  dump_start;
    logic                  dump_valid;
    logic [XLEN-1:0]       dump_data;
    logic [AW-1:0]         dump_idx;
    logic                  dump_ready;
    logic                  busy;

    modport master (
        output reg_write, wr_addr, wr_data, rd_addr,
        output ld_start, ld_valid, ld_data,
        output dump_start, dump_ready,
        input  rd_data, ld_ready, dump_valid, dump_data, dump_idx, busy
    );

    modport slave (
        input  reg_write, wr_addr, wr_data, rd_addr,
        input  ld_start, ld_valid, ld_data,
        input  dump_start, dump_ready,
        output rd_data, ld_ready, dump_valid, dump_data, dump_idx, busy
    );
endinterface

// File: rtl/regfile_multiport.sv
// Multi-read-port register file with x0 hardwired to zero, optional write-to-read forwarding,
// and a bulk LOAD / DUMP streaming engine that walks every register in index order.
module regfile_multiport #(
    parameter int XLEN   = 64,
    parameter int NREG   = 32,
    parameter int AW     = 5,
    parameter int NRD    = 2,
    parameter int BYPASS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    regfile_multiport_if.slave   bus
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DUMP} state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

    state_t          state_q, state_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [XLEN-1:0] regs_q [NREG];

    logic            wen;
    logic [AW-1:0]   waddr;
    logic [XLEN-1:0] wdata;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.ld_start) begin
                    state_d = S_LOAD;
                    idx_d   = '0;
                end else if (bus.dump_start) begin
                    state_d = S_DUMP;
                    idx_d   = '0;
                end
            end
            S_LOAD: begin
                if (bus.ld_valid) begin
                    idx_d = idx_q + AW'(1);
                    if (idx_q == LAST_IDX) state_d = S_IDLE;
                end
            end
            S_DUMP: begin
                if (bus.dump_ready) begin
                    idx_d = idx_q + AW'(1);
                    if (idx_q == LAST_IDX) state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Only one writer exists per cycle: the normal port in IDLE, or the load stream in LOAD.
    always_comb begin
        wen   = 1'b0;
        waddr = '0;
        wdata = '0;
        if (state_q == S_IDLE && bus.reg_write) begin
            wen   = 1'b1;
            waddr = bus.wr_addr;
            wdata = bus.wr_data;
        end else if (state_q == S_LOAD && bus.ld_valid) begin
            wen   = 1'b1;
            waddr = idx_q;
            wdata = bus.ld_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (wen && waddr != '0) regs_q[waddr] <= wdata;
        end
    end

    // Forwarding only applies to the normal write port, so it is suppressed while busy.
    always_comb begin
        bus.rd_data = '0;
        for (int k = 0; k < NRD; k++) begin
            if (bus.rd_addr[k*AW +: AW] == '0) begin
                bus.rd_data[k*XLEN +: XLEN] = '0;
            end else if ((BYPASS != 0) && state_q == S_IDLE && bus.reg_write &&
                         bus.wr_addr == bus.rd_addr[k*AW +: AW]) begin
                bus.rd_data[k*XLEN +: XLEN] = bus.wr_data;
            end else begin
                bus.rd_data[k*XLEN +: XLEN] = regs_q[bus.rd_addr[k*AW +: AW]];
            end
        end
    end

    always_comb begin
        bus.busy       = (state_q != S_IDLE);
        bus.ld_ready   = (state_q == S_LOAD);
        bus.dump_valid = 1'b0;
        bus.dump_idx   = '0;
        bus.dump_data  = '0;
        if (state_q == S_DUMP) begin
            bus.dump_valid = 1'b1;
            bus.dump_idx   = idx_q;
            bus.dump_data  = regs_q[idx_q];
        end
    end

endmodule

// File: tb/tb_regfile_multiport.sv
// Self-checking bench for regfile_multiport: random traffic against an array model, plus
// directed load/dump/reset scenarios on a forwarding instance and a non-forwarding instance.
module tb_regfile_multiport;

    localparam int XLEN = 64;
    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int NRD  = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    regfile_multiport_if #(.XLEN(XLEN), .AW(AW), .NRD(NRD)) bus1 ();
    regfile_multiport_if #(.XLEN(XLEN), .AW(AW), .NRD(NRD)) bus0 ();

    regfile_multiport #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .NRD(NRD), .BYPASS(1)) dutByp (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    regfile_multiport #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .NRD(NRD), .BYPASS(0)) dutNoByp (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0.slave)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [XLEN-1:0] model [NREG];

    task automatic clear_inputs();
        bus1.reg_write  = 1'b0;
        bus1.wr_addr    = '0;
        bus1.wr_data    = '0;
        bus1.rd_addr    = '0;
        bus1.ld_start   = 1'b0;
        bus1.ld_valid   = 1'b0;
        bus1.ld_data    = '0;
        bus1.dump_start = 1'b0;
        bus1.dump_ready = 1'b0;
        bus0.reg_write  = 1'b0;
        bus0.wr_addr    = '0;
        bus0.wr_data    = '0;
        bus0.rd_addr    = '0;
        bus0.ld_start   = 1'b0;
        bus0.ld_valid   = 1'b0;
        bus0.ld_data    = '0;
        bus0.dump_start = 1'b0;
        bus0.dump_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [XLEN-1:0] got;
        clear_inputs();
        for (int i = 0; i < NREG; i++) model[i] = '0;
        rst_n = 1'b0;
        bus1.rd_addr = {AW'(17), AW'(3)};
        #2;
        vectors++;
        if (bus1.busy !== 1'b0 || bus1.ld_ready !== 1'b0 || bus1.dump_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_flags got busy=%b ld_ready=%b dump_valid=%b exp 0/0/0",
                     bus1.busy, bus1.ld_ready, bus1.dump_valid);
        end
        vectors++;
        if (bus1.dump_data !== '0 || bus1.dump_idx !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_dump got data=%h idx=%0d exp 0/0", bus1.dump_data, bus1.dump_idx);
        end
        for (int k = 0; k < NRD; k++) begin
            got = bus1.rd_data[k*XLEN +: XLEN];
            vectors++;
            if (got !== '0) begin
                miscompares++;
                $display("[TB] FAIL reset_read port%0d got %h exp 0", k, got);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_write_read();
        logic            we;
        logic [AW-1:0]   wa;
        logic [XLEN-1:0] wd;
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] exp;
        logic [XLEN-1:0] got;
        @(negedge clk);
        bus1.reg_write = 1'b1;
        bus1.wr_addr   = AW'(5);
        bus1.wr_data   = XLEN'(64'h1234);
        bus1.rd_addr   = '0;
        @(negedge clk);
        model[5] = XLEN'(64'h1234);
        bus1.wr_addr = '0;
        bus1.wr_data = XLEN'(64'hFF);
        bus1.rd_addr = {AW'(0), AW'(5)};
        #1;
        got = bus1.rd_data[0 +: XLEN];
        vectors++;
        if (got !== XLEN'(64'h1234)) begin
            miscompares++;
            $display("[TB] FAIL write_x5 got %h exp 1234", got);
        end
        @(negedge clk);
        bus1.reg_write = 1'b0;
        bus1.rd_addr   = {AW'(0), AW'(0)};
        #1;
        got = bus1.rd_data[XLEN +: XLEN];
        vectors++;
        if (got !== '0) begin
            miscompares++;
            $display("[TB] FAIL write_x0 got %h exp 0", got);
        end
        // Random traffic; port 0 frequently aliases the write address to exercise forwarding.
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            we = 1'($urandom_range(0, 1));
            wa = AW'($urandom_range(0, NREG - 1));
            wd = {$urandom(), $urandom()};
            bus1.reg_write = we;
            bus1.wr_addr   = wa;
            bus1.wr_data   = wd;
            for (int k = 0; k < NRD; k++) begin
                ra = AW'($urandom_range(0, NREG - 1));
                if (k == 0 && $urandom_range(0, 2) == 0) ra = wa;
                bus1.rd_addr[k*AW +: AW] = ra;
            end
            #1;
            for (int k = 0; k < NRD; k++) begin
                ra = bus1.rd_addr[k*AW +: AW];
                if (ra == '0)                exp = '0;
                else if (we && wa == ra)     exp = wd;
                else                         exp = model[ra];
                got = bus1.rd_data[k*XLEN +: XLEN];
                vectors++;
                if (got !== exp) begin
                    miscompares++;
                    $display("[TB] FAIL rand_read n=%0d port%0d addr=%0d got %h exp %h", n, k, ra, got, exp);
                end
            end
            if (we && wa != '0) model[wa] = wd;
        end
        @(negedge clk);
        bus1.reg_write = 1'b0;
    endtask

    task automatic test_bypass();
        logic [XLEN-1:0] got;
        bus1.reg_write = 1'b1;
        bus1.wr_addr   = AW'(7);
        bus1.wr_data   = XLEN'(64'hAA);
        bus1.rd_addr   = {AW'(7), AW'(0)};
        #1;
        got = bus1.rd_data[XLEN +: XLEN];
        vectors++;
        if (got !== XLEN'(64'hAA)) begin
            miscompares++;
            $display("[TB] FAIL bypass_on got %h exp aa", got);
        end
        @(negedge clk);
        model[7] = XLEN'(64'hAA);
        bus1.reg_write = 1'b0;
        bus0.reg_write = 1'b1;
        bus0.wr_addr   = AW'(7);
        bus0.wr_data   = XLEN'(64'h55);
        @(negedge clk);
        bus0.wr_data = XLEN'(64'hAA);
        bus0.rd_addr = {AW'(7), AW'(0)};
        #1;
        got = bus0.rd_data[XLEN +: XLEN];
        vectors++;
        if (got !== XLEN'(64'h55)) begin
            miscompares++;
            $display("[TB] FAIL bypass_off_old got %h exp 55", got);
        end
        @(negedge clk);
        bus0.reg_write = 1'b0;
        #1;
        got = bus0.rd_data[XLEN +: XLEN];
        vectors++;
        if (got !== XLEN'(64'hAA)) begin
            miscompares++;
            $display("[TB] FAIL bypass_off_new got %h exp aa", got);
        end
    endtask

    task automatic test_load_priority();
        int              i;
        int              budget;
        logic [AW-1:0]   wa;
        logic [XLEN-1:0] got;
        logic [XLEN-1:0] exp;
        @(negedge clk);
        bus1.ld_start   = 1'b1;
        bus1.dump_start = 1'b1;
        @(negedge clk);
        bus1.ld_start   = 1'b0;
        bus1.dump_start = 1'b0;
        #1;
        vectors++;
        if (bus1.busy !== 1'b1 || bus1.ld_ready !== 1'b1 || bus1.dump_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL load_priority got busy=%b ld_ready=%b dump_valid=%b exp 1/1/0",
                     bus1.busy, bus1.ld_ready, bus1.dump_valid);
        end
        i = 0;
        budget = 0;
        // Normal writes are attempted every cycle and must be ignored while loading.
        while (i < NREG && budget < 400) begin
            bus1.ld_valid  = 1'($urandom_range(0, 1));
            bus1.ld_data   = XLEN'(i * 3);
            wa             = AW'($urandom_range(1, NREG - 1));
            bus1.reg_write = 1'b1;
            bus1.wr_addr   = wa;
            bus1.wr_data   = {$urandom(), $urandom()};
            bus1.rd_addr   = {AW'(0), wa};
            #1;
            vectors++;
            if (bus1.ld_ready !== 1'b1 || bus1.busy !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL load_ready beat=%0d got ld_ready=%b busy=%b exp 1/1", i, bus1.ld_ready, bus1.busy);
            end
            got = bus1.rd_data[0 +: XLEN];
            vectors++;
            if (got !== model[wa]) begin
                miscompares++;
                $display("[TB] FAIL load_read addr=%0d got %h exp %h", wa, got, model[wa]);
            end
            if (bus1.ld_valid) begin
                if (i != 0) model[i] = XLEN'(i * 3);
                i++;
            end
            @(negedge clk);
            budget++;
        end
        bus1.ld_valid  = 1'b0;
        bus1.reg_write = 1'b0;
        vectors++;
        if (i < NREG) begin
            miscompares++;
            $display("[TB] FAIL load_timeout got %0d beats exp %0d", i, NREG);
        end
        #1;
        vectors++;
        if (bus1.busy !== 1'b0 || bus1.ld_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL load_end got busy=%b ld_ready=%b exp 0/0", bus1.busy, bus1.ld_ready);
        end
        for (int a = 0; a < NREG; a += 2) begin
            bus1.rd_addr = {AW'(a + 1), AW'(a)};
            #1;
            for (int k = 0; k < NRD; k++) begin
                exp = (a + k == 0) ? '0 : XLEN'((a + k) * 3);
                got = bus1.rd_data[k*XLEN +: XLEN];
                vectors++;
                if (got !== exp) begin
                    miscompares++;
                    $display("[TB] FAIL load_content x%0d got %h exp %h", a + k, got, exp);
                end
            end
        end
    endtask

    task automatic test_dump();
        int expIdx;
        int budget;
        @(negedge clk);
        bus1.dump_start = 1'b1;
        @(negedge clk);
        bus1.dump_start = 1'b0;
        expIdx = 0;
        budget = 0;
        while (expIdx < NREG && budget < 400) begin
            bus1.dump_ready = 1'($urandom_range(0, 1));
            #1;
            vectors++;
            if (bus1.dump_valid !== 1'b1 || bus1.busy !== 1'b1 || bus1.dump_idx !== AW'(expIdx)) begin
                miscompares++;
                $display("[TB] FAIL dump_beat got valid=%b busy=%b idx=%0d exp 1/1/%0d",
                         bus1.dump_valid, bus1.busy, bus1.dump_idx, expIdx);
            end
            vectors++;
            if (bus1.dump_data !== model[expIdx]) begin
                miscompares++;
                $display("[TB] FAIL dump_data idx=%0d got %h exp %h", expIdx, bus1.dump_data, model[expIdx]);
            end
            if (bus1.dump_ready) expIdx++;
            @(negedge clk);
            budget++;
        end
        bus1.dump_ready = 1'b0;
        vectors++;
        if (expIdx < NREG) begin
            miscompares++;
            $display("[TB] FAIL dump_timeout got %0d beats exp %0d", expIdx, NREG);
        end
        #1;
        vectors++;
        if (bus1.dump_valid !== 1'b0 || bus1.busy !== 1'b0 || bus1.dump_idx !== '0 || bus1.dump_data !== '0) begin
            miscompares++;
            $display("[TB] FAIL dump_end got valid=%b busy=%b idx=%0d data=%h exp all 0",
                     bus1.dump_valid, bus1.busy, bus1.dump_idx, bus1.dump_data);
        end
    endtask

    task automatic test_reset_mid_dump();
        logic [XLEN-1:0] got;
        @(negedge clk);
        bus1.dump_start = 1'b1;
        @(negedge clk);
        bus1.dump_start = 1'b0;
        bus1.dump_ready = 1'b1;
        repeat (9) @(negedge clk);
        bus1.dump_ready = 1'b0;
        #1;
        vectors++;
        if (bus1.dump_valid !== 1'b1 || bus1.dump_idx !== AW'(9)) begin
            miscompares++;
            $display("[TB] FAIL mid_dump_idx got valid=%b idx=%0d exp 1/9", bus1.dump_valid, bus1.dump_idx);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (bus1.busy !== 1'b0 || bus1.dump_valid !== 1'b0 || bus1.dump_idx !== '0 || bus1.dump_data !== '0) begin
            miscompares++;
            $display("[TB] FAIL abort_dump got busy=%b valid=%b idx=%0d data=%h exp all 0",
                     bus1.busy, bus1.dump_valid, bus1.dump_idx, bus1.dump_data);
        end
        for (int i = 0; i < NREG; i++) model[i] = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int a = 0; a < NREG; a += 2) begin
            bus1.rd_addr = {AW'(a + 1), AW'(a)};
            #1;
            for (int k = 0; k < NRD; k++) begin
                got = bus1.rd_data[k*XLEN +: XLEN];
                vectors++;
                if (got !== '0) begin
                    miscompares++;
                    $display("[TB] FAIL post_reset x%0d got %h exp 0", a + k, got);
                end
            end
        end
        @(negedge clk);
        bus1.reg_write = 1'b1;
        bus1.wr_addr   = AW'(3);
        bus1.wr_data   = XLEN'(64'hBEEF);
        bus1.rd_addr   = '0;
        @(negedge clk);
        bus1.reg_write = 1'b0;
        bus1.rd_addr   = {AW'(0), AW'(3)};
        #1;
        got = bus1.rd_data[0 +: XLEN];
        vectors++;
        if (got !== XLEN'(64'hBEEF)) begin
            miscompares++;
            $display("[TB] FAIL resume_write got %h exp beef", got);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_load_priority();
        test_dump();
        test_reset_mid_dump();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/regfile_multiport.md
REGFILE_MULTIPORT -- requirements
Module: regfile_multiport

Interface
REQ-001 SHALL have parameter XLEN, default 64, register width in bits.
REQ-002 SHALL have parameter NREG, default 32, register count, power of two, 2..64.
REQ-003 SHALL have parameter AW, default 5, address width, equal to log2(NREG).
REQ-004 SHALL have parameter NRD, default 2, read-port count, 1..4.
REQ-005 SHALL have parameter BYPASS, default 1; 1 enables write-to-read forwarding.
REQ-006 SHALL have port clk input 1, single clock, all state on rising edge.
REQ-007 SHALL have port rst_n input 1; reset is asynchronous and active-low.
REQ-008 SHALL have port reg_write input 1, normal-mode write enable.
REQ-009 SHALL have port wr_addr input AW, write register index.
REQ-010 SHALL have port wr_data input XLEN, write data.
REQ-011 SHALL have port rd_addr input NRD*AW, packed read indices, port k at bits [k*AW +: AW].
REQ-012 SHALL have port rd_data output NRD*XLEN, packed read data, port k at [k*XLEN +: XLEN].
REQ-013 SHALL have port ld_start input 1, request bulk load of all registers.
REQ-014 SHALL have port ld_valid input 1, ld_data input XLEN, ld_ready output 1: load stream.
REQ-015 SHALL have port dump_start input 1, request bulk dump of all registers.
REQ-016 SHALL have port dump_valid output 1, dump_data output XLEN, dump_idx output AW, dump_ready input 1: dump stream.
REQ-017 SHALL have port busy output 1, high while in LOAD or DUMP.

Function
REQ-018 SHALL store NREG registers of XLEN bits; register 0 reads as 0 always, writes to it are discarded.
REQ-019 SHALL drive each rd_data port combinationally from rd_addr; address 0 returns 0.
REQ-020 SHALL, when BYPASS=1, reg_write=1, busy=0, wr_addr=rd_addr[k], wr_addr!=0, return wr_data on port k same cycle.
REQ-021 SHALL, when BYPASS=0, return the stored value; new value visible the cycle after the write edge.
REQ-022 SHALL write wr_data to wr_addr on rising clk when reg_write=1 and busy=0; reg_write ignored while busy=1.
REQ-023 SHALL implement FSM states IDLE, LOAD, DUMP with an AW-bit index counter idx.
REQ-024 SHALL, in IDLE, on ld_start=1 go to LOAD with idx=0; else on dump_start=1 go to DUMP with idx=0; ld_start wins if both.
REQ-025 SHALL ignore ld_start and dump_start when not in IDLE.
REQ-026 SHALL assert ld_ready=1 only in LOAD; each cycle ld_valid&&ld_ready writes ld_data to reg[idx] (discarded for idx=0), idx increments.
REQ-027 SHALL leave LOAD for IDLE on the beat that accepts idx=NREG-1; exactly NREG beats per load.
REQ-028 SHALL, in DUMP, drive dump_valid=1, dump_idx=idx, dump_data=reg[idx] (0 for idx=0).
REQ-029 SHALL hold dump_idx and dump_data stable while dump_valid=1 and dump_ready=0.
REQ-030 SHALL advance idx on dump_valid&&dump_ready; leave DUMP for IDLE after the beat at idx=NREG-1.
REQ-031 SHALL serve normal reads during LOAD/DUMP with bypass disabled; LOAD writes are visible next cycle.
REQ-032 SHALL keep dump_valid=0, dump_data=0, dump_idx=0, ld_ready=0 outside the respective state.

Reset
REQ-033 SHALL, on rst_n=0, asynchronously clear all registers, idx, FSM to IDLE; busy, ld_ready, dump_valid, dump_data, dump_idx =0.
REQ-034 SHALL abort an in-progress LOAD or DUMP on reset; no partial state survives.
REQ-035 SHALL resume normal operation on the first rising clk after rst_n deasserts.

Verification
REQ-036 SHALL verify: write x5=0x1234 cycle 0, read port0 addr 5 cycle 1 -> 0x1234; write x0=0xFF -> reads 0.
REQ-037 SHALL verify: BYPASS=1, reg_write x7=0xAA with rd_addr port1=7 same cycle -> rd_data port1=0xAA; BYPASS=0 -> old value.
REQ-038 SHALL verify: ld_start then NREG beats data=i*3 with random ld_valid gaps -> reg[i]=i*3 for i>=1, reg[0]=0, busy falls after last beat.
REQ-039 SHALL verify: dump with dump_ready toggling -> dump_idx 0..NREG-1 in order, data stable under stall, matches stored values.
REQ-040 SHALL verify: ld_start and dump_start together in IDLE -> LOAD entered; reg_write during busy -> no change.
REQ-041 SHALL verify: rst_n low mid-DUMP at idx=9 -> busy=0, dump_valid=0 immediately, all reads 0 after reset.
